// File: rtl/prog_ctrl_pkg.sv
// Shared constants for the program-load sequencer: state encoding,
// memory-select bit and datapath widths.
package prog_ctrl_pkg;

  localparam int unsigned ADR_W       = 15;
  localparam int unsigned WR_ADR_W    = 14;
  localparam int unsigned DAT_W       = 32;
  localparam int unsigned MEM_SEL_BIT = 14;
  localparam int unsigned SETTLE_W    = 8;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_PROG   = 2'b01,
    ST_SETTLE = 2'b10,
    ST_ABORT  = 2'b11
  } state_t;

endpackage

// File: rtl/rise_detect.sv
// One-cycle rising-edge detector: history flop plus combinational rise.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= sig_i;
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/prog_load_ctrl.sv
// Sequencer/arbiter for instruction and data memory write ports shared
// between the CPU core and the UART programmer.
module prog_load_ctrl
  import prog_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 20_000_000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start_pg_i,
  input  logic                upg_wen_i,
  input  logic [ADR_W-1:0]    upg_adr_i,
  input  logic [DAT_W-1:0]    upg_dat_i,
  input  logic                upg_done_i,
  input  logic                cpu_wen_i,
  output logic                rom_wen_o,
  output logic                ram_wen_o,
  output logic                ram_sel_upg_o,
  output logic [WR_ADR_W-1:0] wr_adr_o,
  output logic [DAT_W-1:0]    wr_dat_o,
  output logic                cpu_rst_o,
  output logic                upg_rst_o,
  output logic [1:0]          state_o,
  output logic                err_o,
  output logic [CNT_W-1:0]    word_cnt_o
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0]    TMR_MAX     = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                err_d;
  logic                start_rise, done_rise;

  rise_detect u_start_rise (
    .clock  (clock),
    .reset  (reset),
    .sig_i  (start_pg_i),
    .rise_o (start_rise)
  );

  rise_detect u_done_rise (
    .clock  (clock),
    .reset  (reset),
    .sig_i  (upg_done_i),
    .rise_o (done_rise)
  );

  // Next-state, counters and timers
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    settle_d = settle_q;
    err_d    = err_o;
    unique case (state_q)
      ST_RUN, ST_ABORT: begin
        if (start_rise) begin
          state_d = ST_PROG;
          cnt_d   = '0;
          tmr_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_PROG: begin
        if (upg_wen_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          tmr_d = '0;
        end else if (tmr_q != TMR_MAX) begin
          tmr_d = tmr_q + TMR_W'(1);
        end
        // done beats a simultaneous timeout
        if (done_rise) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end else if (tmr_d == TMR_MAX) begin
          state_d = ST_ABORT;
          err_d   = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d  = ST_RUN;
        else                         settle_d = settle_q + SETTLE_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      tmr_q         <= '0;
      settle_q      <= '0;
      err_o         <= 1'b0;
      cpu_rst_o     <= 1'b0;
      upg_rst_o     <= 1'b1;
      ram_sel_upg_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      settle_q      <= settle_d;
      err_o         <= err_d;
      cpu_rst_o     <= (state_d != ST_RUN);
      upg_rst_o     <= (state_d != ST_PROG);
      ram_sel_upg_o <= (state_d == ST_PROG);
    end
  end

  // Write enables are the only combinational outputs, gated by registered state
  always_comb begin
    rom_wen_o = 1'b0;
    ram_wen_o = 1'b0;
    unique case (state_q)
      ST_RUN:  ram_wen_o = cpu_wen_i;
      ST_PROG: begin
        rom_wen_o = upg_wen_i & ~upg_adr_i[MEM_SEL_BIT];
        ram_wen_o = upg_wen_i &  upg_adr_i[MEM_SEL_BIT];
      end
      default: ;
    endcase
  end

  assign wr_adr_o   = upg_adr_i[WR_ADR_W-1:0];
  assign wr_dat_o   = upg_dat_i;
  assign state_o    = state_q;
  assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Bench for prog_load_ctrl: behavioural session model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_prog_load_ctrl;

  localparam int unsigned P_SETTLE  = 16;
  localparam int unsigned P_TIMEOUT = 100;
  localparam int unsigned P_CNT_W   = 4;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start_pg_i = 1'b0;
  logic               upg_wen_i = 1'b0;
  logic [14:0]        upg_adr_i = '0;
  logic [31:0]        upg_dat_i = '0;
  logic               upg_done_i = 1'b0;
  logic               cpu_wen_i = 1'b0;
  logic               rom_wen_o, ram_wen_o, ram_sel_upg_o;
  logic [13:0]        wr_adr_o;
  logic [31:0]        wr_dat_o;
  logic               cpu_rst_o, upg_rst_o, err_o;
  logic [1:0]         state_o;
  logic [P_CNT_W-1:0] word_cnt_o;

  prog_load_ctrl #(
    .SETTLE_CYCLES  (P_SETTLE),
    .TIMEOUT_CYCLES (P_TIMEOUT),
    .CNT_W          (P_CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start_pg_i    (start_pg_i),
    .upg_wen_i     (upg_wen_i),
    .upg_adr_i     (upg_adr_i),
    .upg_dat_i     (upg_dat_i),
    .upg_done_i    (upg_done_i),
    .cpu_wen_i     (cpu_wen_i),
    .rom_wen_o     (rom_wen_o),
    .ram_wen_o     (ram_wen_o),
    .ram_sel_upg_o (ram_sel_upg_o),
    .wr_adr_o      (wr_adr_o),
    .wr_dat_o      (wr_dat_o),
    .cpu_rst_o     (cpu_rst_o),
    .upg_rst_o     (upg_rst_o),
    .state_o       (state_o),
    .err_o         (err_o),
    .word_cnt_o    (word_cnt_o)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Session model: mode 0 RUN, 1 PROG, 2 SETTLE, 3 ABORT
  int m_mode = 0;
  int m_cnt = 0;
  int m_idle = 0;
  int m_settle_left = 0;
  bit m_err = 1'b0;
  bit m_prev_start = 1'b0;
  bit m_prev_done = 1'b0;
  bit m_srise, m_drise;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_cnt = 0; m_idle = 0; m_settle_left = 0;
      m_err = 1'b0; m_prev_start = 1'b0; m_prev_done = 1'b0;
    end else begin
      m_srise = start_pg_i && !m_prev_start;
      m_drise = upg_done_i && !m_prev_done;
      m_prev_start = start_pg_i;
      m_prev_done  = upg_done_i;
      if (m_mode == 0 || m_mode == 3) begin
        if (m_srise) begin
          m_mode = 1; m_cnt = 0; m_idle = 0; m_err = 1'b0;
        end
      end else if (m_mode == 1) begin
        if (upg_wen_i) begin
          m_cnt = (m_cnt + 1) % (1 << P_CNT_W);
          m_idle = 0;
        end else begin
          m_idle++;
        end
        if (m_drise) begin
          m_mode = 2; m_settle_left = P_SETTLE;
        end else if (m_idle >= P_TIMEOUT) begin
          m_mode = 3; m_err = 1'b1;
        end
      end else begin
        m_settle_left--;
        if (m_settle_left == 0) m_mode = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("state", 64'(state_o), 64'(m_mode));
      chk("cpu_rst", 64'(cpu_rst_o), 64'(m_mode != 0));
      chk("upg_rst", 64'(upg_rst_o), 64'(m_mode != 1));
      chk("ram_sel", 64'(ram_sel_upg_o), 64'(m_mode == 1));
      chk("err", 64'(err_o), 64'(m_err));
      chk("word_cnt", 64'(word_cnt_o), 64'(m_cnt));
      chk("rom_wen", 64'(rom_wen_o), 64'(m_mode == 1 && upg_wen_i && !upg_adr_i[14]));
      chk("ram_wen", 64'(ram_wen_o),
          64'(m_mode == 0 ? cpu_wen_i : (m_mode == 1 && upg_wen_i && upg_adr_i[14])));
      chk("wr_adr", 64'(wr_adr_o), 64'(upg_adr_i & 15'h3fff));
      chk("wr_dat", 64'(wr_dat_o), 64'(upg_dat_i));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic enter_prog();
    start_pg_i = 1'b0;
    tick();
    start_pg_i = 1'b1;
    tick();
    chk("enter_prog", 64'(state_o), 64'd1);
  endtask

  task automatic wait_run();
    int n = 0;
    while (state_o != 2'd0 && n < 60) begin
      tick();
      n++;
    end
    chk("back_to_run", 64'(state_o), 64'd0);
  endtask

  initial begin
    int n;
    int wr_pct;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("lit_rst_state", 64'(state_o), 64'd0);
    chk("lit_rst_cpu_rst", 64'(cpu_rst_o), 64'd0);
    chk("lit_rst_upg_rst", 64'(upg_rst_o), 64'd1);
    chk("lit_rst_err", 64'(err_o), 64'd0);
    cpu_wen_i = 1'b1;
    #1;
    chk("lit_run_ram_wen", 64'(ram_wen_o), 64'd1);
    chk("lit_run_rom_wen", 64'(rom_wen_o), 64'd0);

    // Start request: PROG next cycle, CPU writes blocked
    start_pg_i = 1'b1;
    tick();
    #1;
    chk("lit_prog_state", 64'(state_o), 64'd1);
    chk("lit_prog_cpu_rst", 64'(cpu_rst_o), 64'd1);
    chk("lit_prog_upg_rst", 64'(upg_rst_o), 64'd0);
    chk("lit_prog_cnt", 64'(word_cnt_o), 64'd0);
    chk("lit_prog_cpu_blk", 64'(ram_wen_o), 64'd0);
    cpu_wen_i = 1'b0;

    // Instruction write then data write to the same word address
    upg_wen_i = 1'b1; upg_adr_i = 15'h0005; upg_dat_i = 32'hdeadbeef;
    #1;
    chk("lit_imem_rom", 64'(rom_wen_o), 64'd1);
    chk("lit_imem_ram", 64'(ram_wen_o), 64'd0);
    chk("lit_imem_adr", 64'(wr_adr_o), 64'h5);
    tick();
    upg_adr_i = 15'h4005;
    #1;
    chk("lit_dmem_ram", 64'(ram_wen_o), 64'd1);
    chk("lit_dmem_rom", 64'(rom_wen_o), 64'd0);
    chk("lit_dmem_adr", 64'(wr_adr_o), 64'h5);
    tick();
    upg_wen_i = 1'b0;
    #1;
    chk("lit_cnt_two", 64'(word_cnt_o), 64'd2);

    // Done: exactly P_SETTLE cycles of SETTLE, then RUN
    upg_done_i = 1'b1;
    tick();
    chk("lit_settle_state", 64'(state_o), 64'd2);
    n = 0;
    while (state_o == 2'd2 && n < 40) begin
      n++;
      tick();
    end
    chk("lit_settle_len", 64'(n), 64'd16);
    chk("lit_settle_exit", 64'(state_o), 64'd0);
    chk("lit_settle_cpu_rst", 64'(cpu_rst_o), 64'd0);
    upg_done_i = 1'b0;

    // Idle PROG aborts after P_TIMEOUT cycles
    enter_prog();
    n = 0;
    while (state_o != 2'd3 && n < 200) begin
      tick();
      n++;
    end
    chk("lit_timeout_len", 64'(n), 64'd100);
    chk("lit_abort_err", 64'(err_o), 64'd1);
    chk("lit_abort_cpu_rst", 64'(cpu_rst_o), 64'd1);
    enter_prog();
    chk("lit_abort_err_clr", 64'(err_o), 64'd0);

    // Done rise on the same edge the timeout would fire: done wins
    repeat (99) tick();
    chk("lit_pre_timeout", 64'(state_o), 64'd1);
    upg_done_i = 1'b1;
    tick();
    chk("lit_done_wins", 64'(state_o), 64'd2);
    chk("lit_done_wins_err", 64'(err_o), 64'd0);
    wait_run();
    upg_done_i = 1'b0;

    // Write in the done-rise cycle is still counted
    enter_prog();
    upg_wen_i = 1'b1; upg_adr_i = 15'h0010;
    tick();
    upg_done_i = 1'b1;
    tick();
    upg_wen_i = 1'b0;
    chk("lit_done_wr_state", 64'(state_o), 64'd2);
    chk("lit_done_wr_cnt", 64'(word_cnt_o), 64'd2);
    wait_run();
    upg_done_i = 1'b0;

    // Counter wraps: 17 writes in a 4-bit counter leave 1
    enter_prog();
    upg_wen_i = 1'b1;
    repeat (17) tick();
    upg_wen_i = 1'b0;
    #1;
    chk("lit_cnt_wrap", 64'(word_cnt_o), 64'd1);

    // Reset mid-write: enables drop at once
    upg_wen_i = 1'b1; upg_adr_i = 15'h4001;
    #1;
    chk("lit_pre_rst_ram", 64'(ram_wen_o), 64'd1);
    reset = 1'b1;
    #1;
    chk("lit_rst_ram_wen", 64'(ram_wen_o), 64'd0);
    chk("lit_rst_rom_wen", 64'(rom_wen_o), 64'd0);
    chk("lit_rst_mid_state", 64'(state_o), 64'd0);
    chk("lit_rst_mid_cnt", 64'(word_cnt_o), 64'd0);
    tick();
    reset = 1'b0;
    upg_wen_i = 1'b0;

    // Randomized traffic against the model
    wr_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       wr_pct = 0;
          1:       wr_pct = 30;
          default: wr_pct = 90;
        endcase
      end
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 19) == 0) start_pg_i = ~start_pg_i;
      if ($urandom_range(0, 59) == 0) upg_done_i = ~upg_done_i;
      upg_wen_i = ($urandom_range(0, 99) < wr_pct);
      upg_adr_i = 15'($urandom);
      upg_dat_i = $urandom;
      cpu_wen_i = $urandom_range(0, 1) == 1;
    end
    tick();
    reset = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_load_ctrl.md
Name: prog_load_ctrl

Overview:
Sequencer and arbiter for the shared instruction and data memories, sitting between the UART programmer, the CPU core and the programrom/dmemory32 write ports.
- In RUN it passes CPU data-memory writes through and blocks the programmer.
- In PROG it holds the CPU in reset, routes programmer writes to instruction or data memory by address bit 14, counts words written and enforces an inactivity timeout.
- Replaces the ad-hoc upg_rst register at top level.

Parameters:
SETTLE_CYCLES, 16, cycles CPU reset stays asserted after programming completes (1..255)
TIMEOUT_CYCLES, 25'd20_000_000, PROG inactivity limit in clock cycles before abort
CNT_W, 16, width of the accepted-word counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
start_pg_i  in  1  debounced programming request, level
upg_wen_i  in  1  programmer write strobe, one word per high cycle
upg_adr_i  in  15  programmer word address; bit14 1=data mem, 0=instr mem
upg_dat_i  in  32  programmer write data
upg_done_i  in  1  programmer transfer complete, level
cpu_wen_i  in  1  CPU data-memory write enable (MemWrite)
rom_wen_o  out  1  instruction-memory write enable
ram_wen_o  out  1  data-memory write enable (CPU or programmer)
ram_sel_upg_o  out  1  1 = data-memory port owned by programmer
wr_adr_o  out  14  programmer word address (upg_adr_i[13:0])
wr_dat_o  out  32  programmer write data
cpu_rst_o  out  1  CPU core reset
upg_rst_o  out  1  programmer reset, active-high (1 = programmer idle)
state_o  out  2  00 RUN, 01 PROG, 10 SETTLE, 11 ABORT
err_o  out  1  sticky timeout flag
word_cnt_o  out  CNT_W  words accepted in last/current PROG session

Behaviour:
- Clocking and reset
  - All state in flops on rising edge of clock.
  - reset asynchronously forces: state=RUN, cpu_rst_o=0, upg_rst_o=1, err_o=0, word_cnt_o=0, timers=0, edge-detect history regs=0.
- Edge detection: start_pg_i and upg_done_i pass through one history flop each; rise = cur & ~prev.
- RUN (00)
  - cpu_rst_o=0, upg_rst_o=1, ram_sel_upg_o=0.
  - ram_wen_o=cpu_wen_i; rom_wen_o=0; upg_wen_i ignored.
  - start_pg rise -> PROG next cycle; word_cnt_o cleared, err_o cleared, timeout timer cleared.
- PROG (01)
  - cpu_rst_o=1, upg_rst_o=0, ram_sel_upg_o=1; cpu_wen_i ignored.
  - When upg_wen_i=1: rom_wen_o=~upg_adr_i[14] and ram_wen_o=upg_adr_i[14], combinational from inputs gated by registered state; word_cnt_o increments (wraps at 2^CNT_W-1 -> 0); timeout timer cleared.
  - When upg_wen_i=0: timer increments, saturating at TIMEOUT_CYCLES.
  - upg_done rise -> SETTLE, settle timer cleared.
  - Timer reaching TIMEOUT_CYCLES -> ABORT, err_o=1.
  - Done rise and timeout in the same cycle: done wins.
  - A write in the cycle done rises is still accepted and counted.
  - start_pg rise while in PROG: ignored.
- SETTLE (10)
  - cpu_rst_o=1, upg_rst_o=1, no writes from any source.
  - Counts SETTLE_CYCLES cycles, then RUN; cpu_rst_o deasserts on the cycle state becomes RUN.
- ABORT (11)
  - cpu_rst_o=1, upg_rst_o=1, no writes.
  - Only start_pg rise exits, to PROG (counter and err cleared as from RUN).
- Outputs
  - wr_adr_o/wr_dat_o are always upg_adr_i[13:0]/upg_dat_i.
  - cpu_rst_o, upg_rst_o, state_o, err_o and word_cnt_o are registered outputs. The write enables are the only combinational outputs.
- reset mid-PROG: immediate return to RUN; writes stop the same instant (enables gated by state).

Decomposition:
- Shared package prog_ctrl_pkg: state encoding constants (ST_RUN, ST_PROG, ST_SETTLE, ST_ABORT), memory-select bit index 14.
- One sub-module is natural: rise_detect (1-bit history flop plus rise output, async active-high reset), instantiated twice.

Test Plan:
- Release reset -> state_o=00, cpu_rst_o=0, upg_rst_o=1; cpu_wen_i=1 gives ram_wen_o=1, rom_wen_o=0.
- start_pg_i 0->1 -> next cycle state_o=01, cpu_rst_o=1, upg_rst_o=0, word_cnt_o=0; cpu_wen_i=1 gives ram_wen_o=0.
- In PROG: upg_wen_i with adr 15'h0005 then 15'h4005 -> first rom_wen_o=1/ram_wen_o=0, second ram_wen_o=1/rom_wen_o=0, wr_adr_o=14'h0005 both times, word_cnt_o=2.
- upg_done_i rise -> state 10 for exactly 16 cycles with cpu_rst_o=1, then state 00, cpu_rst_o=0.
- TIMEOUT_CYCLES=100, no writes in PROG -> state 11 at cycle 100, err_o=1; next start_pg rise -> PROG with err_o=0.
- reset asserted mid-PROG during upg_wen_i=1 -> rom_wen_o/ram_wen_o drop immediately, state 00, word_cnt_o=0.
